dma_read_engine: RTL
====================

DMA_READ_ENGINE -- requirements
Module: dma_read_engine

Interface
REQ-001 Params: none; data path fixed at 512 bits (16 x 32-bit words), keep 64 bits.
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 rstn  in  1  reset, synchronous, active-low.
REQ-004 m_axis_dma_read_cmd  axis_mem_cmd.master  valid/ready, address 64, length 32  read command to DMA.
REQ-005 s_axis_dma_read_data  axi_stream.slave  valid/ready, data 512, keep 64, last  read data returned by DMA.
REQ-006 control_reg  in  16x32  [3:2] base_addr (hi,lo), [4] dma_length bytes, [5] ops, [6] once_length bytes, [7][0] start.
REQ-007 status_reg  out  16x32  [0] th_cnt, [1] data_op_nums, [2] err_cnt, [3] last_err_cnt, [4] first_err_beat; [15:5] = 0.

Function
REQ-008 All control_reg fields registered once (1-cycle delay) before use; start gets 3 further register stages (start_r..start_rrrr).
REQ-009 Start event = start_r & ~start_rr (rising edge); clears op_nums, data_op_nums, beat_cnt, err_cnt, last_err_cnt, th_cnt; sets first_err_beat = 0xFFFF_FFFF; c_addr <= base_addr.
REQ-010 once_length: multiple of 64, >= 64; beats_per_op = once_length>>6 (32-bit arithmetic); other values undefined.
REQ-011 Command FSM states IDLE, READ_CMD, JUDGE; IDLE->READ_CMD on start event; READ_CMD->JUDGE on cmd valid&ready; JUDGE->IDLE if op_nums == ops, else ->READ_CMD.
REQ-012 cmd.valid = (state == READ_CMD); cmd.address = c_addr; cmd.length = once_length.
REQ-013 op_nums increments by 1 on each cmd handshake.
REQ-014 c_addr on handshake: if c_addr + 2*once_length > base_addr + dma_length then c_addr <= base_addr, else c_addr <= c_addr + once_length (no command crosses buffer end).
REQ-015 ops = 0: FSM issues exactly one command then returns IDLE in JUDGE only if op_nums==0 never holds -> ops = 0 is illegal; bench never uses it.
REQ-016 s_axis_dma_read_data.ready = 1 whenever rstn = 1 (sink never stalls); 0 during reset.
REQ-017 beat_cnt (32 b) counts beats within current op; on beat handshake: beat_cnt <= (beat_cnt == beats_per_op-1) ? 0 : beat_cnt+1.
REQ-018 Expected data for beat k: word j (bits 32j+31:32j) = 16k + j, j = 0..15, 32-bit wrap.
REQ-019 Data error: any word mismatch or keep != all-ones on a handshake beat -> err_cnt +1 (saturating at 0xFFFF_FFFF); first error sets first_err_beat = global beat index (beats since start) if still 0xFFFF_FFFF.
REQ-020 Last error: last != (beat_cnt == beats_per_op-1) on handshake -> last_err_cnt +1 (saturating); beat_cnt still follows REQ-017, not last.
REQ-021 data_op_nums +1 on handshake with beat_cnt == beats_per_op-1.
REQ-022 th_cnt +1 every cycle after start event while data_op_nums != ops; holds once equal; restarted only by next start event.
REQ-023 Data and error checking pipelined at most 2 stages; status values settle within 3 cycles of final beat.
REQ-024 Start event during active run: all counters restart per REQ-009, FSM -> READ_CMD from any state; in-flight beats of old run are checked against new counters (benchmark host must not do this).
REQ-025 Simultaneous cmd handshake and data beat: both counted independently in same cycle.
REQ-026 status_reg outputs driven from registers only.

Reset
REQ-027 rstn=0 sampled on edge: state=IDLE, cmd.valid=0, data.ready=0, c_addr=0, all counters 0, first_err_beat=0xFFFF_FFFF, status_reg[4:0] = {0xFFFF_FFFF,0,0,0,0}.
REQ-028 Reset mid-run aborts immediately; no command or count continues after rstn returns high until next start event.

Verification
REQ-029 base=0x1_0000_0000, dma_length=0x1000, once_length=0x200, ops=4, correct pattern, last on beat 7 -> 4 cmds at +0,+0x200,+0x400,+0x600; status[1]=4, [2]=0, [3]=0; th_cnt frozen.
REQ-030 dma_length=0x400, once_length=0x200, ops=5 -> addresses base,+0x200,base,+0x200,base.
REQ-031 Corrupt word 3 of global beat 10 (once_length=0x200) -> err_cnt=1, first_err_beat=10, data_op_nums unaffected.
REQ-032 last asserted on beat 6 instead of 7 of op 0 -> last_err_cnt=2 (beats 6 and 7), data_op_nums still counts op.
REQ-033 cmd.ready held low 20 cycles then high -> cmd.valid stays high, address stable, single op_nums increment per handshake.
REQ-034 rstn low 1 cycle mid-run -> all status per REQ-027 next cycle; new start gives clean run with counts from 0.

Source files
------------

// File: rtl/dma_read_engine.sv
// DMA read benchmark engine: issues fixed-size read commands over a buffer and
// checks the returned data stream against a counting pattern, reporting counters.
module dma_read_engine (
    input  logic              clk,
    input  logic              rstn,
    output logic              m_axis_dma_read_cmd_valid_o,
    input  logic              m_axis_dma_read_cmd_ready_i,
    output logic [63:0]       m_axis_dma_read_cmd_address_o,
    output logic [31:0]       m_axis_dma_read_cmd_length_o,
    input  logic              s_axis_dma_read_data_valid_i,
    output logic              s_axis_dma_read_data_ready_o,
    input  logic [511:0]      s_axis_dma_read_data_data_i,
    input  logic [63:0]       s_axis_dma_read_data_keep_i,
    input  logic              s_axis_dma_read_data_last_i,
    input  logic [15:0][31:0] control_reg_i,
    output logic [15:0][31:0] status_reg_o
);

    typedef enum logic [1:0] {StIdle, StReadCmd, StJudge} state_e;

    logic [63:0] base_addr_q;
    logic [31:0] dma_length_q;
    logic [31:0] ops_q;
    logic [31:0] once_length_q;
    logic        start_r_q;
    logic        start_rr_q;

    state_e      state_q;
    logic        cmd_valid_q;
    logic [63:0] c_addr_q;
    logic [31:0] op_nums_q;

    logic [31:0] beat_cnt_q;
    logic [31:0] glob_beat_q;
    logic        p1_valid_q;
    logic        p1_data_err_q;
    logic        p1_last_err_q;
    logic        p1_op_done_q;
    logic [31:0] p1_beat_idx_q;

    logic        run_q;
    logic [31:0] th_cnt_q;
    logic [31:0] data_op_nums_q;
    logic [31:0] err_cnt_q;
    logic [31:0] last_err_cnt_q;
    logic [31:0] first_err_beat_q;

    logic        start_evt;
    logic        cmd_fire;
    logic        beat_fire;
    logic [31:0] bpo_m1;
    logic        beat_last;
    logic        data_err;
    logic [63:0] once64;
    logic [63:0] addr_step;
    logic        addr_wrap;
    logic        unused_ctrl;

    assign unused_ctrl = ^{control_reg_i[1:0], control_reg_i[7][31:1], control_reg_i[15:8]};

    assign start_evt = start_r_q & ~start_rr_q;
    assign cmd_fire  = cmd_valid_q & m_axis_dma_read_cmd_ready_i;
    assign beat_fire = s_axis_dma_read_data_valid_i & rstn;
    assign bpo_m1    = (once_length_q >> 6) - 32'd1;
    assign beat_last = (beat_cnt_q == bpo_m1);

    // Next command must fit entirely below base + dma_length, else wrap to base.
    assign once64    = {32'd0, once_length_q};
    assign addr_step = c_addr_q + once64;
    assign addr_wrap = (addr_step + once64) > (base_addr_q + {32'd0, dma_length_q});

    always_comb begin
        data_err = (s_axis_dma_read_data_keep_i != '1);
        for (int j = 0; j < 16; j++) begin
            if (s_axis_dma_read_data_data_i[32*j +: 32] != ((glob_beat_q << 4) + 32'(j))) begin
                data_err = 1'b1;
            end
        end
    end

    assign s_axis_dma_read_data_ready_o  = rstn;
    assign m_axis_dma_read_cmd_valid_o   = cmd_valid_q;
    assign m_axis_dma_read_cmd_address_o = c_addr_q;
    assign m_axis_dma_read_cmd_length_o  = once_length_q;

    always_comb begin
        status_reg_o    = '0;
        status_reg_o[0] = th_cnt_q;
        status_reg_o[1] = data_op_nums_q;
        status_reg_o[2] = err_cnt_q;
        status_reg_o[3] = last_err_cnt_q;
        status_reg_o[4] = first_err_beat_q;
    end

    // Control capture and command FSM.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            base_addr_q   <= '0;
            dma_length_q  <= '0;
            ops_q         <= '0;
            once_length_q <= '0;
            start_r_q     <= 1'b0;
            start_rr_q    <= 1'b0;
            state_q       <= StIdle;
            cmd_valid_q   <= 1'b0;
            c_addr_q      <= '0;
            op_nums_q     <= '0;
        end else begin
            base_addr_q   <= {control_reg_i[3], control_reg_i[2]};
            dma_length_q  <= control_reg_i[4];
            ops_q         <= control_reg_i[5];
            once_length_q <= control_reg_i[6];
            start_r_q     <= control_reg_i[7][0];
            start_rr_q    <= start_r_q;
            if (start_evt) begin
                state_q     <= StReadCmd;
                cmd_valid_q <= 1'b1;
                c_addr_q    <= base_addr_q;
                op_nums_q   <= '0;
            end else begin
                case (state_q)
                    StReadCmd: begin
                        if (cmd_fire) begin
                            state_q     <= StJudge;
                            cmd_valid_q <= 1'b0;
                            op_nums_q   <= op_nums_q + 32'd1;
                            c_addr_q    <= addr_wrap ? base_addr_q : addr_step;
                        end
                    end
                    StJudge: begin
                        if (op_nums_q == ops_q) begin
                            state_q <= StIdle;
                        end else begin
                            state_q     <= StReadCmd;
                            cmd_valid_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q     <= StIdle;
                        cmd_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Data check: stage 1 captures per-beat verdicts, stage 2 updates counters.
    always_ff @(posedge clk) begin
        if (!rstn || start_evt) begin
            beat_cnt_q       <= '0;
            glob_beat_q      <= '0;
            p1_valid_q       <= 1'b0;
            p1_data_err_q    <= 1'b0;
            p1_last_err_q    <= 1'b0;
            p1_op_done_q     <= 1'b0;
            p1_beat_idx_q    <= '0;
            run_q            <= rstn;
            th_cnt_q         <= '0;
            data_op_nums_q   <= '0;
            err_cnt_q        <= '0;
            last_err_cnt_q   <= '0;
            first_err_beat_q <= '1;
        end else begin
            if (beat_fire) begin
                beat_cnt_q  <= beat_last ? 32'd0 : beat_cnt_q + 32'd1;
                glob_beat_q <= glob_beat_q + 32'd1;
            end
            p1_valid_q    <= beat_fire;
            p1_data_err_q <= data_err;
            p1_last_err_q <= s_axis_dma_read_data_last_i != beat_last;
            p1_op_done_q  <= beat_last;
            p1_beat_idx_q <= glob_beat_q;

            if (p1_valid_q) begin
                if (p1_data_err_q && err_cnt_q != '1) begin
                    err_cnt_q <= err_cnt_q + 32'd1;
                end
                if (p1_data_err_q && first_err_beat_q == '1) begin
                    first_err_beat_q <= p1_beat_idx_q;
                end
                if (p1_last_err_q && last_err_cnt_q != '1) begin
                    last_err_cnt_q <= last_err_cnt_q + 32'd1;
                end
                if (p1_op_done_q) begin
                    data_op_nums_q <= data_op_nums_q + 32'd1;
                end
            end

            if (run_q) begin
                if (data_op_nums_q != ops_q) begin
                    th_cnt_q <= th_cnt_q + 32'd1;
                end else begin
                    run_q <= 1'b0;
                end
            end
        end
    end

endmodule
